// File: rtl/pipe_mux_n_if.sv
// Handshake bundle for pipe_mux_n: the selection input side, the registered output
// side and the sticky select-error flag.
interface pipe_mux_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic                    err_clr;

  modport master (
    output in_data, in_sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_idx, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_idx, out_valid, sel_err
  );
endinterface

// File: rtl/pipe_mux_n.sv
// N:1 word selector feeding a registered output stage with a one-word skid buffer,
// so a downstream stall never drops an accepted result.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipe_mux_n_if.slave bus
);

  // Encoding is {main_vld, skid_vld}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] pick_word(
    input logic [NUM_IN*WIDTH-1:0] data,
    input logic [SEL_W-1:0]        sel
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w = (int'(sel) == k) ? data[k*WIDTH +: WIDTH] : w;
    end
    return w;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_idx_q, main_idx_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_idx_q, skid_idx_d;
  logic             sel_err_q, sel_err_d;

  logic             in_ready;
  logic             acc;
  logic             in_range;
  logic [WIDTH-1:0] sel_word;

  // in_ready depends only on registers and rst, never on out_ready.
  assign in_ready = ~rst & (state_q != ST_FULL);
  assign acc      = bus.in_valid & in_ready;
  assign in_range = (int'(bus.in_sel) < NUM_IN);
  assign sel_word = pick_word(bus.in_data, bus.in_sel);

  // Next-state and datapath selection for the main/skid stage and error flag.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_idx_d  = main_idx_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;

    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d     = ST_ONE;
          main_data_d = sel_word;
          main_idx_d  = bus.in_sel;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc && bus.out_ready) begin
          state_d     = ST_ONE;
          main_data_d = sel_word;
          main_idx_d  = bus.in_sel;
        end else if (acc) begin
          state_d     = ST_FULL;
          skid_data_d = sel_word;
          skid_idx_d  = bus.in_sel;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_idx_d  = skid_idx_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Set beats clear when both happen in the same cycle.
    if (acc && !in_range) begin
      sel_err_d = 1'b1;
    end else if (bus.err_clr) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // State, data and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_idx_q  <= '0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_idx_q  <= main_idx_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_idx   = main_idx_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed and randomised checks of pipe_mux_n: an 8-input instance for data flow
// and a 6-input instance for out-of-range select handling.
module tb_pipe_mux_n;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [34:0] sb[$];
  logic [34:0] exp_w;

  pipe_mux_n_if #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) b8();
  pipe_mux_n_if #(.WIDTH(32), .NUM_IN(6), .SEL_W(3)) b6();

  pipe_mux_n #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  pipe_mux_n #(.WIDTH(32), .NUM_IN(6), .SEL_W(3)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    b8.in_valid = 1'b0; b8.in_sel = 3'd0; b8.out_ready = 1'b0; b8.err_clr = 1'b0;
    b6.in_valid = 1'b0; b6.in_sel = 3'd0; b6.out_ready = 1'b0; b6.err_clr = 1'b0;
    for (int k = 0; k < 8; k++) b8.in_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    for (int k = 0; k < 6; k++) b6.in_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(b8.in_ready), 64'd0);
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_out_data", 64'(b8.out_data), 64'd0);
    chk("rst_sel_err", 64'(b8.sel_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(b8.in_ready), 64'd1);

    // Single select with one-cycle latency
    b8.in_valid = 1'b1; b8.in_sel = 3'd5; b8.out_ready = 1'b1;
    tick();
    chk("sel5_valid", 64'(b8.out_valid), 64'd1);
    chk("sel5_data", 64'(b8.out_data), 64'h1000_0005);
    chk("sel5_idx", 64'(b8.out_idx), 64'd5);

    // Streaming at one word per cycle
    for (int i = 0; i < 8; i++) begin
      b8.in_sel = 3'(i);
      #1;
      chk("stream_in_ready", 64'(b8.in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(b8.out_valid), 64'd1);
      chk("stream_data", 64'(b8.out_data), 64'h1000_0000 + 64'(i));
      chk("stream_idx", 64'(b8.out_idx), 64'(i));
    end
    b8.in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(b8.out_valid), 64'd0);

    // Backpressure fills the skid buffer
    b8.out_ready = 1'b0; b8.in_valid = 1'b1; b8.in_sel = 3'd2;
    tick();
    chk("bp_first_data", 64'(b8.out_data), 64'h1000_0002);
    b8.in_sel = 3'd3;
    tick();
    chk("bp_full_in_ready", 64'(b8.in_ready), 64'd0);
    chk("bp_hold_data", 64'(b8.out_data), 64'h1000_0002);
    b8.in_sel = 3'd4;
    tick();
    chk("bp_ignored_data", 64'(b8.out_data), 64'h1000_0002);
    chk("bp_ignored_idx", 64'(b8.out_idx), 64'd2);
    chk("bp_ignored_in_ready", 64'(b8.in_ready), 64'd0);
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    tick();
    chk("bp_second_valid", 64'(b8.out_valid), 64'd1);
    chk("bp_second_data", 64'(b8.out_data), 64'h1000_0003);
    tick();
    chk("bp_empty_valid", 64'(b8.out_valid), 64'd0);
    chk("bp_empty_in_ready", 64'(b8.in_ready), 64'd1);

    // Out-of-range select on the 6-input instance
    b6.out_ready = 1'b1; b6.in_valid = 1'b1; b6.in_sel = 3'd7;
    tick();
    b6.in_valid = 1'b0;
    chk("oor_valid", 64'(b6.out_valid), 64'd1);
    chk("oor_data", 64'(b6.out_data), 64'd0);
    chk("oor_idx", 64'(b6.out_idx), 64'd7);
    chk("oor_sel_err", 64'(b6.sel_err), 64'd1);
    chk("inrange_no_err", 64'(b8.sel_err), 64'd0);
    tick();
    chk("oor_sticky", 64'(b6.sel_err), 64'd1);
    b6.err_clr = 1'b1;
    tick();
    b6.err_clr = 1'b0;
    chk("oor_cleared", 64'(b6.sel_err), 64'd0);
    b6.in_valid = 1'b1; b6.in_sel = 3'd7; b6.err_clr = 1'b1;
    tick();
    b6.in_valid = 1'b0; b6.err_clr = 1'b0;
    chk("oor_set_wins", 64'(b6.sel_err), 64'd1);
    b6.in_valid = 1'b1; b6.in_sel = 3'd5;
    tick();
    b6.in_valid = 1'b0;
    chk("n6_sel5_data", 64'(b6.out_data), 64'h1000_0005);
    chk("n6_sel5_err_held", 64'(b6.sel_err), 64'd1);

    // Reset while FULL discards both buffered words
    b8.out_ready = 1'b0; b8.in_valid = 1'b1; b8.in_sel = 3'd1;
    tick();
    b8.in_sel = 3'd6;
    tick();
    b8.in_valid = 1'b0;
    chk("full_before_rst", 64'(b8.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(b8.in_ready), 64'd0);
    tick();
    chk("rst_mid_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_mid_in_ready_hi", 64'(b8.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_after_in_ready", 64'(b8.in_ready), 64'd1);
    b8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", 64'(b8.out_valid), 64'd0);
    end

    // Random valid/ready against a FIFO scoreboard
    sb.delete();
    for (int c = 0; c < 1000; c++) begin
      b8.in_valid  = 1'($urandom_range(0, 1));
      b8.in_sel    = 3'($urandom_range(0, 7));
      b8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b8.out_valid && b8.out_ready) begin
        chk("rnd_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("rnd_word", 64'({b8.out_idx, b8.out_data}), 64'(exp_w));
        end
      end
      if (b8.in_valid && b8.in_ready) begin
        sb.push_back({b8.in_sel, 32'h1000_0000 + {29'd0, b8.in_sel}});
      end
      tick();
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (b8.out_valid) begin
        chk("drain_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("drain_word", 64'({b8.out_idx, b8.out_data}), 64'(exp_w));
        end
      end
      tick();
    end
    chk("rnd_sb_empty", 64'(sb.size()), 64'd0);
    chk("rnd_out_idle", 64'(b8.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
